// File: rtl/ram_burst_arbiter_if.sv
// Signal bundle between ram_burst_arbiter, its requesting masters and the shared RAM port.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface ram_burst_arbiter_if #(
   parameter int NUM_MASTERS = 4,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int BURST_W     = 8
);
   logic [NUM_MASTERS-1:0]         iMRead;
   logic [NUM_MASTERS-1:0]         iMWrite;
   logic [NUM_MASTERS*ADDR_W-1:0]  iMAddress;
   logic [NUM_MASTERS*BURST_W-1:0] iMBurstcount;
   logic [NUM_MASTERS*DATA_W-1:0]  iMWritedata;
   logic [NUM_MASTERS-1:0]         oMWaitrequest;
   logic [NUM_MASTERS-1:0]         oMDatavalid;
   logic [DATA_W-1:0]              oMData;
   logic                           oSRead;
   logic [ADDR_W-1:0]              oSAddress;
   logic [BURST_W-1:0]             oSBurstcount;
   logic [DATA_W-1:0]              iSData;
   logic                           iSWaitrequest;
   logic                           iSDatavalid;
   logic                           oSWrite;
   logic [ADDR_W-1:0]              oSWriteaddress;
   logic [DATA_W-1:0]              oSWritedata;
   logic                           oTimeout;

   modport slave (
      input  iMRead, iMWrite, iMAddress, iMBurstcount, iMWritedata,
      input  iSData, iSWaitrequest, iSDatavalid,
      output oMWaitrequest, oMDatavalid, oMData,
      output oSRead, oSAddress, oSBurstcount,
      output oSWrite, oSWriteaddress, oSWritedata, oTimeout
   );

   modport master (
      output iMRead, iMWrite, iMAddress, iMBurstcount, iMWritedata,
      output iSData, iSWaitrequest, iSDatavalid,
      input  oMWaitrequest, oMDatavalid, oMData,
      input  oSRead, oSAddress, oSBurstcount,
      input  oSWrite, oSWriteaddress, oSWritedata, oTimeout
   );
endinterface

// File: rtl/ram_burst_arbiter.sv
// Round-robin arbiter sharing one burst-read / single-write RAM port among several masters,
// with a sticky watchdog that abandons a stalled burst.
//
// state  | meaning
// IDLE   | pick next requester after the round-robin pointer, capture its operands
// ISSUE  | hold until the RAM drops waitrequest, then register the strobe
// LAUNCH | one cycle of strobe and master acknowledge
// BURST  | route read beats to the owner until the beat counter runs out
// DRAIN  | wait for the RAM to finish the burst (waitrequest low)
module ram_burst_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int BURST_W     = 8,
   parameter int TIMEOUT     = 1024
) (
   input  logic                   clk,
   input  logic                   reset_n,
   ram_burst_arbiter_if.slave     bus
);
   localparam int PW = $clog2(NUM_MASTERS);
   localparam int WW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_LAUNCH, S_BURST, S_DRAIN} state_t;

   state_t                 state_q;
   logic [PW-1:0]          ptr_q;
   logic [PW-1:0]          own_q;
   logic                   wr_q;
   logic [ADDR_W-1:0]      addr_q;
   logic [DATA_W-1:0]      data_q;
   logic [BURST_W-1:0]     bc_q;
   logic [BURST_W-1:0]     beats_q;
   logic [WW-1:0]          wd_q;
   logic                   to_q;
   logic                   sread_q;
   logic                   swrite_q;
   logic [NUM_MASTERS-1:0] mwait_q;

   logic [NUM_MASTERS-1:0] req_c;
   logic [NUM_MASTERS-1:0] dv_c;
   logic [PW-1:0]          cand_c;
   logic [PW-1:0]          win_d;
   logic                   win_vld;
   logic                   in_burst;

   // A master being acknowledged this cycle must not be considered again.
   assign req_c = (bus.iMRead | bus.iMWrite) & mwait_q;

   always_comb begin
      win_vld = 1'b0;
      win_d   = '0;
      cand_c  = '0;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         cand_c = PW'((int'(ptr_q) + i) % NUM_MASTERS);
         if (!win_vld && req_c[cand_c]) begin
            win_vld = 1'b1;
            win_d   = cand_c;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         ptr_q    <= PW'(NUM_MASTERS - 1);
         own_q    <= '0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         bc_q     <= '0;
         beats_q  <= '0;
         wd_q     <= '0;
         to_q     <= 1'b0;
         sread_q  <= 1'b0;
         swrite_q <= 1'b0;
         mwait_q  <= '1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (win_vld) begin
                  own_q   <= win_d;
                  ptr_q   <= win_d;
                  wr_q    <= bus.iMWrite[win_d];
                  addr_q  <= bus.iMAddress[int'(win_d)*ADDR_W +: ADDR_W];
                  data_q  <= bus.iMWritedata[int'(win_d)*DATA_W +: DATA_W];
                  bc_q    <= bus.iMBurstcount[int'(win_d)*BURST_W +: BURST_W];
                  state_q <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (!bus.iSWaitrequest) begin
                  if (wr_q) begin
                     swrite_q <= 1'b1;
                  end else begin
                     sread_q <= 1'b1;
                     beats_q <= bc_q;
                  end
                  mwait_q[own_q] <= 1'b0;
                  state_q        <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               swrite_q <= 1'b0;
               sread_q  <= 1'b0;
               mwait_q  <= '1;
               wd_q     <= '0;
               if (wr_q)
                  state_q <= S_IDLE;
               else if (bc_q == '0)
                  state_q <= S_DRAIN;
               else
                  state_q <= S_BURST;
            end
            S_BURST: begin
               if (bus.iSDatavalid) begin
                  beats_q <= beats_q - 1'b1;
                  wd_q    <= '0;
                  if (beats_q == BURST_W'(1))
                     state_q <= S_DRAIN;
               end else if (wd_q == WW'(TIMEOUT - 1)) begin
                  to_q    <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
            end
            S_DRAIN: begin
               if (!bus.iSWaitrequest) begin
                  state_q <= S_IDLE;
               end else if (wd_q == WW'(TIMEOUT - 1)) begin
                  to_q    <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Read beats pass straight through, zero latency, only while a burst is owned.
   assign in_burst = (state_q == S_BURST);

   always_comb begin
      dv_c = '0;
      if (in_burst && bus.iSDatavalid)
         dv_c[own_q] = 1'b1;
   end

   assign bus.oMDatavalid    = dv_c;
   assign bus.oMData         = in_burst ? bus.iSData : '0;
   assign bus.oMWaitrequest  = mwait_q;
   assign bus.oSRead         = sread_q;
   assign bus.oSAddress      = addr_q;
   assign bus.oSBurstcount   = bc_q;
   assign bus.oSWrite        = swrite_q;
   assign bus.oSWriteaddress = addr_q;
   assign bus.oSWritedata    = data_q;
   assign bus.oTimeout       = to_q;
endmodule
